// File: rtl/lisp_test_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lisp_test_sequencer                                                      |
// | On-chip regression runner: loads test images into the lisp core's RAM,   |
// | runs each one with a timeout, and tallies per-test and suite results.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module lisp_test_sequencer #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 10,
    parameter int IMAGE_WORDS   = 17,
    parameter int NUM_TESTS     = 4,
    parameter int RESET_CYCLES  = 3,
    parameter int SETTLE_CYCLES = 3,
    parameter int TIMEOUT       = 65535,
    localparam int TW = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1,
    localparam int CW = $clog2(NUM_TESTS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    output logic [TW-1:0]         img_test,
    output logic [ADDR_WIDTH-1:0] img_addr,
    input  logic [DATA_WIDTH-1:0] img_data,
    input  logic [DATA_WIDTH-1:0] desc_expr,
    input  logic [DATA_WIDTH-1:0] desc_expected,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  core_rst,
    output logic                  core_start,
    output logic [DATA_WIDTH-1:0] core_switches,
    input  logic                  core_halt,
    input  logic                  core_error,
    input  logic [DATA_WIDTH-1:0] core_val,
    output logic                  busy,
    output logic                  done,
    output logic                  result_valid,
    output logic                  result_pass,
    output logic [1:0]            result_code,
    output logic [CW-1:0]         pass_count,
    output logic [CW-1:0]         fail_count,
    output logic [TW-1:0]         first_fail_idx,
    output logic [DATA_WIDTH-1:0] first_fail_val
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_RESET  = 4'd1,
        S_LOAD   = 4'd2,
        S_ARM    = 4'd3,
        S_START  = 4'd4,
        S_WAIT   = 4'd5,
        S_SETTLE = 4'd6,
        S_CHECK  = 4'd7,
        S_NEXT   = 4'd8,
        S_DONE   = 4'd9
    } state_t;

    localparam logic [31:0]     RESET_LAST     = 32'(RESET_CYCLES - 1);
    localparam logic [31:0]     LOAD_LAST      = 32'(IMAGE_WORDS);
    localparam logic [31:0]     LOAD_ADDR_LAST = 32'(IMAGE_WORDS - 1);
    localparam logic [31:0]     SETTLE_LAST    = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0]     TIMEOUT_LAST   = 32'(TIMEOUT - 1);
    localparam logic [TW-1:0]   LAST_TEST      = TW'(NUM_TESTS - 1);
    localparam logic [CW-1:0]   COUNT_MAX      = CW'(NUM_TESTS);
    localparam logic [1:0]      CODE_PASS      = 2'b00;
    localparam logic [1:0]      CODE_MISMATCH  = 2'b01;
    localparam logic [1:0]      CODE_ERROR     = 2'b10;
    localparam logic [1:0]      CODE_TIMEOUT   = 2'b11;

    state_t                  state;
    logic [31:0]             cnt;
    logic                    saw_error;
    logic [DATA_WIDTH-1:0]   sample_val;

    // ROM data arrives one cycle after its address, which is exactly when the
    // registered write strobe for that address is presented.
    assign mem_wdata = mem_we ? img_data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            saw_error      <= 1'b0;
            sample_val     <= '0;
            img_test       <= '0;
            img_addr       <= '0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            core_rst       <= 1'b1;
            core_start     <= 1'b0;
            core_switches  <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            result_valid   <= 1'b0;
            result_pass    <= 1'b0;
            result_code    <= '0;
            pass_count     <= '0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            first_fail_val <= '0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (go) begin
                        pass_count     <= '0;
                        fail_count     <= '0;
                        first_fail_idx <= '0;
                        first_fail_val <= '0;
                        result_pass    <= 1'b0;
                        result_code    <= '0;
                        img_test       <= '0;
                        cnt            <= '0;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        state          <= S_RESET;
                    end
                end
                S_RESET: begin
                    core_rst <= 1'b1;
                    // img_test already points at this test, so its descriptor is valid here
                    if (cnt == '0) begin
                        core_switches <= desc_expr;
                    end
                    if (cnt == RESET_LAST) begin
                        cnt      <= '0;
                        img_addr <= '0;
                        state    <= S_LOAD;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_LOAD: begin
                    if (cnt < LOAD_LAST) begin
                        mem_we   <= 1'b1;
                        mem_addr <= img_addr;
                        if (cnt < LOAD_ADDR_LAST) begin
                            img_addr <= img_addr + ADDR_WIDTH'(1);
                        end
                    end else begin
                        mem_we <= 1'b0;
                    end
                    if (cnt == LOAD_LAST) begin
                        cnt      <= '0;
                        img_addr <= '0;
                        core_rst <= 1'b0;
                        state    <= S_ARM;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_ARM: begin
                    core_start <= 1'b1;
                    state      <= S_START;
                end
                S_START: begin
                    core_start <= 1'b0;
                    cnt        <= '0;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_error || core_halt) begin
                        saw_error <= core_error;
                        cnt       <= '0;
                        state     <= S_SETTLE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        result_valid <= 1'b1;
                        result_pass  <= 1'b0;
                        result_code  <= CODE_TIMEOUT;
                        sample_val   <= core_val;
                        state        <= S_CHECK;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        result_valid <= 1'b1;
                        sample_val   <= core_val;
                        if (saw_error) begin
                            result_pass <= 1'b0;
                            result_code <= CODE_ERROR;
                        end else if (core_val == desc_expected) begin
                            result_pass <= 1'b1;
                            result_code <= CODE_PASS;
                        end else begin
                            result_pass <= 1'b0;
                            result_code <= CODE_MISMATCH;
                        end
                        state <= S_CHECK;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_CHECK: begin
                    if (result_pass) begin
                        if (pass_count != COUNT_MAX) begin
                            pass_count <= pass_count + CW'(1);
                        end
                    end else begin
                        if (fail_count != COUNT_MAX) begin
                            fail_count <= fail_count + CW'(1);
                        end
                        // a zero fail count before this increment marks the first failure
                        if (fail_count == '0) begin
                            first_fail_idx <= img_test;
                            first_fail_val <= sample_val;
                        end
                    end
                    core_rst <= 1'b1;
                    state    <= S_NEXT;
                end
                S_NEXT: begin
                    if (img_test == LAST_TEST) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        img_test <= img_test + TW'(1);
                        cnt      <= '0;
                        state    <= S_RESET;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lisp_test_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_lisp_test_sequencer                                                   |
// | Directed bench: ROM/core models plus a per-test vector table.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_lisp_test_sequencer;

    localparam int DW = 16;
    localparam int AW = 10;
    localparam int IW = 17;
    localparam int NT = 4;
    localparam int TO = 20;
    localparam int TW = 2;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          go;
    logic [TW-1:0] img_test;
    logic [AW-1:0] img_addr;
    logic [DW-1:0] img_data;
    logic [DW-1:0] desc_expr;
    logic [DW-1:0] desc_expected;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          core_rst;
    logic          core_start;
    logic [DW-1:0] core_switches;
    logic          core_halt;
    logic          core_error;
    logic [DW-1:0] core_val;
    logic          busy;
    logic          done;
    logic          result_valid;
    logic          result_pass;
    logic [1:0]    result_code;
    logic [CW-1:0] pass_count;
    logic [CW-1:0] fail_count;
    logic [TW-1:0] first_fail_idx;
    logic [DW-1:0] first_fail_val;

    always #5 clk = ~clk;

    lisp_test_sequencer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IMAGE_WORDS(IW), .NUM_TESTS(NT),
        .RESET_CYCLES(3), .SETTLE_CYCLES(3), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .go(go),
        .img_test(img_test), .img_addr(img_addr), .img_data(img_data),
        .desc_expr(desc_expr), .desc_expected(desc_expected),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_rst(core_rst), .core_start(core_start), .core_switches(core_switches),
        .core_halt(core_halt), .core_error(core_error), .core_val(core_val),
        .busy(busy), .done(done),
        .result_valid(result_valid), .result_pass(result_pass), .result_code(result_code),
        .pass_count(pass_count), .fail_count(fail_count),
        .first_fail_idx(first_fail_idx), .first_fail_val(first_fail_val)
    );

    typedef struct {
        int          delay;
        logic [15:0] val;
        bit          err;
        bit          hang;
        bit          exp_pass;
        logic [1:0]  exp_code;
    } vec_t;

    vec_t vecs [NT];
    int   tests_run    = 0;
    int   tests_failed = 0;

    function automatic logic [DW-1:0] rom_word(input logic [TW-1:0] t, input logic [AW-1:0] a);
        return {t, 4'h3, a} ^ 16'h0C05;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ROM with one-cycle read latency and combinational descriptors
    always @(posedge clk) img_data <= rom_word(img_test, img_addr);
    assign desc_expr     = 16'h000E + {14'd0, img_test};
    assign desc_expected = 16'h0008;

    // Core model: halts (optionally with error) 'delay' cycles after start
    int ccnt;
    bit running;
    always @(posedge clk) begin
        if (core_rst) begin
            core_halt  <= 1'b0;
            core_error <= 1'b0;
            core_val   <= '0;
            running    <= 1'b0;
            ccnt       <= 0;
        end else if (core_start) begin
            running <= 1'b1;
            ccnt    <= 1;
        end else if (running) begin
            if (!vecs[img_test].hang && ccnt == vecs[img_test].delay) begin
                core_halt  <= 1'b1;
                core_error <= vecs[img_test].err;
                core_val   <= vecs[img_test].val;
                running    <= 1'b0;
            end else begin
                ccnt <= ccnt + 1;
            end
        end
    end

    // Write-port and start-pulse monitor
    int wexp    = 0;
    int nstarts = 0;
    always @(negedge clk) begin
        if (!busy) wexp = 0;
        if (mem_we) begin
            check("load_addr", mem_addr, wexp);
            check("load_data", mem_wdata, rom_word(img_test, mem_addr));
            wexp++;
        end
        if (core_start) begin
            check("start_under_rst", core_rst, 0);
            check("writes_before_start", wexp, IW);
            wexp = 0;
            nstarts++;
        end
    end

    task automatic start_go(input int exp_pc);
        @(negedge clk);
        check("pre_go_pass_count", pass_count, exp_pc);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        check("go_busy", busy, 1);
        check("go_done", done, 0);
        check("go_pass_count", pass_count, 0);
        check("go_fail_count", fail_count, 0);
    endtask

    task automatic run_test(input int i, input bit poke_go);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 300) begin
            @(negedge clk);
            n++;
            if (core_start) seen = 1'b1;
        end
        check("start_seen", seen, 1);
        check("switches", core_switches, 16'h000E + i);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (poke_go) go = (n == 3);
            if (result_valid) seen = 1'b1;
        end
        go = 1'b0;
        check("result_seen", seen, 1);
        if (vecs[i].hang) check("timeout_latency", n, TO + 1);
        check("result_pass", result_pass, vecs[i].exp_pass);
        check("result_code", result_code, vecs[i].exp_code);
        check("one_start", nstarts, 1);
        nstarts = 0;
    endtask

    task automatic run_suite();
        int n;
        for (int i = 0; i < NT; i++) run_test(i, i == 0);
        n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("done", done, 1);
        check("done_busy", busy, 0);
        check("done_core_rst", core_rst, 1);
        check("pass_count", pass_count, 1);
        check("fail_count", fail_count, 3);
        check("first_fail_idx", first_fail_idx, 1);
        check("first_fail_val", first_fail_val, 16'h0005);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit seen;
        vecs[0] = '{10, 16'h0008, 1'b0, 1'b0, 1'b1, 2'b00};
        vecs[1] = '{6,  16'h0005, 1'b0, 1'b0, 1'b0, 2'b01};
        vecs[2] = '{4,  16'h0008, 1'b1, 1'b0, 1'b0, 2'b10};
        vecs[3] = '{0,  16'h0000, 1'b0, 1'b1, 1'b0, 2'b11};

        rst = 1'b1;
        go  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_core_rst", core_rst, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_core_start", core_start, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_switches", core_switches, 0);
        check("rst_pass_count", pass_count, 0);

        // First suite, with a go pulse during test 0's WAIT
        start_go(0);
        run_suite();

        // Rerun from DONE: counts must clear before the rerun
        start_go(1);
        run_suite();

        // Reset in the middle of test 1's load, then a fresh run
        start_go(1);
        run_test(0, 1'b0);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (mem_we && mem_addr == 10'd7 && img_test == 2'd1) seen = 1'b1;
        end
        check("reached_word7", seen, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_mem_we", mem_we, 0);
        check("midrst_core_rst", core_rst, 1);
        check("midrst_busy", busy, 0);
        check("midrst_pass_count", pass_count, 0);
        check("midrst_fail_count", fail_count, 0);

        start_go(0);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 50) begin
            @(negedge clk);
            n++;
            if (mem_we) seen = 1'b1;
        end
        check("reload_seen", seen, 1);
        check("reload_first_addr", mem_addr, 0);
        run_suite();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
